// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: widths, op codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int ALUCTRL_W = 3;

    // Op codes understood by alu; the arbiter forwards them without decoding.
    localparam logic [ALUCTRL_W-1:0] OP_AND  = 3'b000;
    localparam logic [ALUCTRL_W-1:0] OP_OR   = 3'b001;
    localparam logic [ALUCTRL_W-1:0] OP_ADD  = 3'b010;
    localparam logic [ALUCTRL_W-1:0] OP_XOR  = 3'b011;
    localparam logic [ALUCTRL_W-1:0] OP_ANDN = 3'b100;
    localparam logic [ALUCTRL_W-1:0] OP_ORN  = 3'b101;
    localparam logic [ALUCTRL_W-1:0] OP_SUB  = 3'b110;
    localparam logic [ALUCTRL_W-1:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two ALU clients and alu_arbiter.
// Latency: n/a (wiring only).
// Backpressure: req*_ready from arbiter, rsp*_ready from clients.
// Ports: reqN_valid/ready/a/b/op, rspN_valid/ready/result for N=0,1, plus busy/owner status.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic [ALUCTRL_W-1:0] req0_op;
    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic [WIDTH-1:0]     rsp0_result;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic [ALUCTRL_W-1:0] req1_op;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [WIDTH-1:0]     rsp1_result;

    logic                 busy;
    logic                 owner;

    // Client side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result,
        input  req1_ready, rsp1_valid, rsp1_result,
        input  busy, owner
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result,
        output req1_ready, rsp1_valid, rsp1_result,
        output busy, owner
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by the arbiter's clients.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b operands; alucontrol op code; result.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ALUCTRL_W-1:0] alucontrol,
    output logic [WIDTH-1:0]     result
);

    logic lt;

    always_comb begin
        lt     = ($signed(a) < $signed(b));
        result = '0;
        case (alucontrol)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_XOR:  result = a ^ b;
            OP_ANDN: result = a & ~b;
            OP_ORN:  result = a | ~b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready clients.
// Latency: accept -> rsp_valid two cycles later; 3-cycle minimum issue interval.
// Backpressure: result held in RESP while owner's rsp_ready is low; no new accept meanwhile.
// Ports: clk, reset (sync, active high); bus = alu_arbiter_if.slave (requests, responses, busy, owner).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic                 last_grant;   // doubles as owner of the op in flight
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [ALUCTRL_W-1:0] op_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     alu_result;

    logic any_valid;
    logic grant;
    logic accept;
    logic own_rsp_ready;
    logic in_resp;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a          (a_q),
        .b          (b_q),
        .alucontrol (op_q),
        .result     (alu_result)
    );

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        // Contention goes to whoever did not win last; otherwise the lone requester.
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
        accept        = (state == IDLE) && any_valid && !reset;
        own_rsp_ready = last_grant ? bus.rsp1_ready : bus.rsp0_ready;
        in_resp       = (state == RESP) && !reset;

        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (own_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while reset is held, even
    // though the state register only clears on the next edge.
    assign bus.req0_ready  = accept & ~grant;
    assign bus.req1_ready  = accept &  grant;
    assign bus.rsp0_valid  = in_resp & ~last_grant;
    assign bus.rsp1_valid  = in_resp &  last_grant;
    assign bus.rsp0_result = result_q;
    assign bus.rsp1_result = result_q;
    assign bus.busy        = (state != IDLE) && !reset;
    assign bus.owner       = reset ? 1'b1 : last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // requester 0 wins the first contention
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant;
                a_q        <= grant ? bus.req1_a  : bus.req0_a;
                b_q        <= grant ? bus.req1_b  : bus.req0_b;
                op_q       <= grant ? bus.req1_op : bus.req0_op;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences, random traffic.
// Latency: n/a.
// Backpressure: bench drives rsp_ready patterns including long stalls.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Standalone ALU for the pass-through comparison.
    logic [W-1:0] ref_a, ref_b, ref_res;
    logic [2:0]   ref_op;
    alu #(.WIDTH(W)) u_ref (
        .a          (ref_a),
        .b          (ref_b),
        .alucontrol (ref_op),
        .result     (ref_res)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          who;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic bit rdy(input bit w);
        return w ? bus.req1_ready : bus.req0_ready;
    endfunction
    function automatic bit rspv(input bit w);
        return w ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction
    function automatic logic [31:0] rsp_res(input bit w);
        return w ? bus.rsp1_result : bus.rsp0_result;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit w, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        if (w) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic drop_req(input bit w);
        if (w) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic set_rsp_ready(input bit w, input bit v);
        if (w) bus.rsp1_ready = v;
        else   bus.rsp0_ready = v;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.rsp0_ready = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.rsp1_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req0_ready"}, bus.req0_ready, 0);
        chk({tag, "_req1_ready"}, bus.req1_ready, 0);
        chk({tag, "_rsp0_valid"}, bus.rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, bus.rsp1_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_owner"}, bus.owner, 1);
    endtask

    // One isolated transaction: entered and left just after a rising edge, with DUT idle.
    task automatic single_op(input bit who, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input string tag);
        int n;
        bit other_seen;
        drive_req(who, op, a, b);
        set_rsp_ready(who, 1'b1);
        n = 0;
        other_seen = 0;
        @(negedge clk);
        while (!rdy(who) && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, rdy(who), 1);
        chk({tag, "_other_ready"}, rdy(!who), 0);
        tick();
        drop_req(who);
        n = 1;
        @(negedge clk);
        while (!rspv(who) && n < 10) begin
            if (rspv(!who)) other_seen = 1;
            tick();
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_result"}, rsp_res(who), exp);
        chk({tag, "_other_rsp"}, other_seen | rspv(!who), 0);
        tick();
        @(negedge clk);
        chk({tag, "_done"}, rspv(who), 0);
        set_rsp_ready(who, 1'b0);
        tick();
    endtask

    initial begin
        bit          pend, pw, last, acc0, acc1, v0, v1, er0, er1;
        int          age;
        logic [31:0] pres;

        vt[0] = '{1'b0, 3'b000, 32'h10000001, 32'hFFFFFFFF, 32'h10000001};
        vt[1] = '{1'b1, 3'b001, 32'h00000001, 32'h000000F0, 32'h000000F1};
        vt[2] = '{1'b0, 3'b000, 32'h1100E000, 32'h1100F001, 32'h1100E000};
        vt[3] = '{1'b1, 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vt[4] = '{1'b0, 3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        vt[5] = '{1'b1, 3'b111, 32'h80000000, 32'h00000001, 32'h00000001};
        vt[6] = '{1'b0, 3'b111, 32'h00000005, 32'h00000003, 32'h00000000};
        vt[7] = '{1'b1, 3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vt[8] = '{1'b0, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000};
        vt[9] = '{1'b1, 3'b101, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF};

        ref_a = '0; ref_b = '0; ref_op = '0;

        // Reset values with both requesters pushing.
        reset = 1'b1;
        clear_inputs();
        tick();
        drive_req(0, 3'b010, 32'h1, 32'h2);
        drive_req(1, 3'b010, 32'h3, 32'h4);
        @(negedge clk);
        chk_reset_outputs("rst");
        tick();
        do_reset();

        // Vector table, alternating requesters; first entry is requester 0 alone after reset.
        for (int i = 0; i < 10; i++) begin
            single_op(vt[i].who, vt[i].op, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Both continuously valid from the first cycle after reset.
        do_reset();
        drive_req(0, 3'b001, 32'h00000001, 32'h000000F0);
        drive_req(1, 3'b000, 32'h1100E000, 32'h1100F001);
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int k = 0; k < 12; k++) begin
            bit ew;
            ew = bit'((k / 3) % 2);
            @(negedge clk);
            chk($sformatf("alt_busy%0d", k), bus.busy, (k % 3) != 0);
            if (k % 3 == 0) begin
                chk($sformatf("alt_grant0_%0d", k), bus.req0_ready, !ew);
                chk($sformatf("alt_grant1_%0d", k), bus.req1_ready, ew);
            end else if (k % 3 == 1) begin
                chk($sformatf("alt_owner%0d", k), bus.owner, ew);
            end else begin
                chk($sformatf("alt_rspv%0d", k), rspv(ew), 1);
                chk($sformatf("alt_res%0d", k), rsp_res(ew), ew ? 32'h1100E000 : 32'h000000F1);
            end
            tick();
        end
        clear_inputs();

        // Back-pressure on requester 1 while requester 0 waits.
        drive_req(1, 3'b010, 32'h5, 32'h7);
        @(negedge clk);
        chk("bp_req1_acc", bus.req1_ready, 1);
        tick();
        drop_req(1);
        drive_req(0, 3'b110, 32'd10, 32'd3);
        @(negedge clk);
        chk("bp_exec_req0_ready", bus.req0_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_rsp1_valid%0d", i), bus.rsp1_valid, 1);
            chk($sformatf("bp_rsp1_result%0d", i), bus.rsp1_result, 32'hC);
            chk($sformatf("bp_req0_ready%0d", i), bus.req0_ready, 0);
            tick();
        end
        bus.rsp1_ready = 1;
        @(negedge clk);
        chk("bp_release_req0_ready", bus.req0_ready, 0);
        tick();
        bus.rsp1_ready = 0;
        @(negedge clk);
        chk("bp_req0_accept", bus.req0_ready, 1);
        bus.rsp0_ready = 1;
        tick();
        drop_req(0);
        tick();
        @(negedge clk);
        chk("bp_rsp0_valid", bus.rsp0_valid, 1);
        chk("bp_rsp0_result", bus.rsp0_result, 32'd7);
        tick();
        clear_inputs();

        // Reset while in EXEC.
        drive_req(0, 3'b000, 32'h12345678, 32'h0F0F0F0F);
        bus.rsp0_ready = 1;
        @(negedge clk);
        chk("rexec_acc", bus.req0_ready, 1);
        tick();
        reset = 1'b1;
        drive_req(0, 3'b001, 32'h1, 32'h1);
        drive_req(1, 3'b001, 32'h1, 32'h1);
        @(negedge clk);
        chk_reset_outputs("rexec");
        tick();
        clear_inputs();
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rexec_after_rsp0_%0d", i), bus.rsp0_valid, 0);
            chk($sformatf("rexec_after_rsp1_%0d", i), bus.rsp1_valid, 0);
            chk($sformatf("rexec_after_busy%0d", i), bus.busy, 0);
            tick();
        end
        clear_inputs();

        // Reset while in RESP, owner 1 in flight.
        drive_req(1, 3'b010, 32'h1, 32'h2);
        @(negedge clk);
        chk("rresp_acc", bus.req1_ready, 1);
        tick();
        drop_req(1);
        tick();
        @(negedge clk);
        chk("rresp_in_resp", bus.rsp1_valid, 1);
        reset = 1'b1;
        drive_req(0, 3'b001, 32'h00000001, 32'h000000F0);
        drive_req(1, 3'b000, 32'h1100E000, 32'h1100F001);
        #1;
        chk_reset_outputs("rresp");
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rresp_first_win0", bus.req0_ready, 1);
        chk("rresp_first_lose1", bus.req1_ready, 0);
        chk("rresp_no_rsp1", bus.rsp1_valid, 0);
        bus.rsp0_ready = 1;
        tick();
        clear_inputs();
        bus.rsp0_ready = 1;
        tick();
        tick();
        @(negedge clk);
        chk("rresp_idle_busy", bus.busy, 0);
        tick();
        clear_inputs();

        // Pass-through of op 111 from requester 1.
        ref_a = 32'hFFFFFFFE; ref_b = 32'h00000003; ref_op = 3'b111;
        #1;
        chk("passthru_ref_model", ref_res, alu_model(ref_op, ref_a, ref_b));
        single_op(1'b1, ref_op, ref_a, ref_b, ref_res, "passthru");

        // Random traffic against a transaction-level model.
        do_reset();
        pend = 0; pw = 0; last = 1; age = 0; pres = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) != 0)
                drive_req(0, 3'($urandom_range(0, 7)), $urandom(), $urandom());
            if (!bus.req1_valid && $urandom_range(0, 2) != 0)
                drive_req(1, 3'($urandom_range(0, 7)), $urandom(), $urandom());
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            v0  = bus.req0_valid;
            v1  = bus.req1_valid;
            er0 = !pend && v0 && (!v1 || last);
            er1 = !pend && v1 && (!v0 || !last);
            chk($sformatf("rnd_ready0_c%0d", cyc), bus.req0_ready, er0);
            chk($sformatf("rnd_ready1_c%0d", cyc), bus.req1_ready, er1);
            chk($sformatf("rnd_busy_c%0d", cyc), bus.busy, pend);
            chk($sformatf("rnd_owner_c%0d", cyc), bus.owner, last);
            chk($sformatf("rnd_rsp0v_c%0d", cyc), bus.rsp0_valid, pend && age >= 2 && !pw);
            chk($sformatf("rnd_rsp1v_c%0d", cyc), bus.rsp1_valid, pend && age >= 2 && pw);
            if (pend && age >= 2)
                chk($sformatf("rnd_result_c%0d", cyc), rsp_res(pw), pres);
            acc0 = er0;
            acc1 = er1;
            if (pend) begin
                if (age >= 2 && (pw ? bus.rsp1_ready : bus.rsp0_ready)) pend = 0;
                else age++;
            end
            if (acc0 || acc1) begin
                pend = 1;
                pw   = acc1;
                last = acc1;
                age  = 1;
                pres = acc1 ? alu_model(bus.req1_op, bus.req1_a, bus.req1_b)
                            : alu_model(bus.req0_op, bus.req0_a, bus.req0_b);
            end
            tick();
            if (acc0) drop_req(0);
            if (acc1) drop_req(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
